// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide (multu, mult, divu, div) with HI/LO results,
// flush abort and busy/done handshake; one shift-add or shift-subtract step per cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             divzero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state, state_n;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] p;
    logic [WIDTH-1:0]   m;
    logic [1:0]         op_r;
    logic               sa, sb, dz;

    logic               a_neg, b_neg, start_ok, dz_start, neg;
    logic [WIDTH-1:0]   a_mag, b_mag, q, r, res_hi, res_lo;
    logic [WIDTH:0]     mul_sum, div_r, div_d;
    logic [2*WIDTH-1:0] mul_nxt, div_nxt, prod;

    assign a_neg    = op[0] & srca[WIDTH-1];
    assign b_neg    = op[0] & srcb[WIDTH-1];
    assign a_mag    = a_neg ? -srca : srca;
    assign b_mag    = b_neg ? -srcb : srcb;
    assign start_ok = (state == IDLE) && start && !flush;
    assign dz_start = op[1] && (srcb == '0);
    assign busy     = (state != IDLE);

    // p holds {accumulator, multiplier} for multiply and {remainder, dividend/quotient} for divide
    assign mul_sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
    assign mul_nxt = {mul_sum, p[WIDTH-1:1]};
    assign div_r   = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    assign div_d   = div_r - {1'b0, m};
    assign div_nxt = {div_d[WIDTH] ? div_r[WIDTH-1:0] : div_d[WIDTH-1:0], p[WIDTH-2:0], ~div_d[WIDTH]};

    // sa/sb are zero for unsigned ops, so the corrections below need no op check
    assign neg    = sa ^ sb;
    assign prod   = neg ? -p : p;
    assign q      = neg ? -p[WIDTH-1:0] : p[WIDTH-1:0];
    assign r      = sa ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
    assign res_hi = dz ? p[2*WIDTH-1:WIDTH] : op_r[1] ? r : prod[2*WIDTH-1:WIDTH];
    assign res_lo = dz ? p[WIDTH-1:0] : op_r[1] ? q : prod[WIDTH-1:0];

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start_ok ? (dz_start ? FIX : RUN) : IDLE;
            RUN:     state_n = flush ? IDLE : (cnt == CW'(WIDTH - 1)) ? FIX : RUN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            p       <= '0;
            m       <= '0;
            op_r    <= '0;
            sa      <= 1'b0;
            sb      <= 1'b0;
            dz      <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            divzero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start_ok) begin
                op_r <= op;
                sa   <= a_neg;
                sb   <= b_neg;
                dz   <= dz_start;
                cnt  <= '0;
                m    <= op[1] ? b_mag : a_mag;
                p    <= dz_start ? {srca, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, op[1] ? a_mag : b_mag};
            end else if (state == RUN && !flush) begin
                cnt <= cnt + 1'b1;
                p   <= op_r[1] ? div_nxt : mul_nxt;
            end else if (state == FIX && !flush) begin
                hi      <= res_hi;
                lo      <= res_lo;
                divzero <= dz;
                done    <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit (WIDTH=32) with hand-computed results.
module tb_muldiv_unit;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, flush = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] srca = '0, srcb = '0;
    logic        busy, done, divzero;
    logic [31:0] hi, lo;
    int          checks = 0, failures = 0, lat = 0, bc = 0;
    logic        seen;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo), .divzero(divzero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op = o; srca = a; srcb = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("accept_busy", {63'd0, busy}, 64'd1);
        chk("accept_nodone", {63'd0, done}, 64'd0);
    endtask

    task automatic wait_done();
        lat = 0;
        bc = int'(busy);
        while (!done && lat < 100) begin
            @(posedge clk);
            #1 lat++;
            bc += int'(busy);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_dz", {63'd0, divzero}, 64'd0);
        @(negedge clk) reset = 1'b0;

        go(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done();
        chk("multu_lat", 64'(lat), 64'd33);
        chk("multu_busy", 64'(bc), 64'd33);
        chk("multu_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);

        go(2'b01, 32'hFFFFFFFD, 32'd5);
        wait_done();
        chk("mult_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);

        go(2'b01, 32'h80000000, 32'h80000000);
        wait_done();
        chk("mult_minmin", {hi, lo}, 64'h40000000_00000000);

        go(2'b11, 32'hFFFFFFF9, 32'd2);
        wait_done();
        chk("div_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

        go(2'b11, 32'h80000000, 32'hFFFFFFFF);
        wait_done();
        chk("div_ovf", {hi, lo}, 64'h00000000_80000000);
        chk("div_ovf_dz", {63'd0, divzero}, 64'd0);

        go(2'b10, 32'd100, 32'd0);
        wait_done();
        chk("dz_lat", 64'(lat), 64'd1);
        chk("dz_busy", 64'(bc), 64'd1);
        chk("dz_hilo", {hi, lo}, 64'h00000064_FFFFFFFF);
        chk("dz_flag", {63'd0, divzero}, 64'd1);

        go(2'b10, 32'd100, 32'd7);
        wait_done();
        chk("divu_hilo", {hi, lo}, {32'd2, 32'd14});
        chk("divu_dz", {63'd0, divzero}, 64'd0);

        go(2'b10, 32'd9, 32'd3);
        repeat (4) @(posedge clk);
        @(negedge clk);
        op = 2'b01; srca = 32'd5; srcb = 32'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("stable_hilo", {hi, lo}, {32'd2, 32'd14});
        wait_done();
        chk("ign_start_hilo", {hi, lo}, {32'd0, 32'd3});

        go(2'b00, 32'h12345678, 32'd9);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1; start = 1'b1; op = 2'b00; srca = 32'd1; srcb = 32'd1;
        @(posedge clk);
        #1 flush = 1'b0; start = 1'b0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1 seen = seen | done | busy;
        end
        chk("flush_quiet", {63'd0, seen}, 64'd0);
        chk("flush_hilo", {hi, lo}, {32'd0, 32'd3});

        go(2'b00, 32'd5, 32'd5);
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_done", {63'd0, done}, 64'd0);
        chk("arst_hilo", {hi, lo}, 64'd0);
        chk("arst_dz", {63'd0, divzero}, 64'd0);
        @(negedge clk) reset = 1'b0;

        go(2'b00, 32'd6, 32'd7);
        wait_done();
        chk("post_rst_lat", 64'(lat), 64'd33);
        chk("post_rst_hilo", {hi, lo}, {32'd0, 32'd42});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
